// File: rtl/cdb_arbiter_if.sv
// Result-broadcast bus between the execution-unit producers, the CDB arbiter
// and the CDB consumers. The slave modport is the arbiter's view; the master
// modport is the view of the producers and consumers around it.
interface cdb_arbiter_if #(
  parameter int NREQ    = 3,
  parameter int ID_BITS = 4,
  parameter int DATA_W  = 32
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*ID_BITS-1:0] req_id;
  logic [NREQ*DATA_W-1:0]  req_value;
  logic [NREQ-1:0]         req_ready;

  logic                    cdb_rdy_1;
  logic [ID_BITS-1:0]      cdb_id_1;
  logic [DATA_W-1:0]       cdb_value_1;
  logic                    cdb_rdy_2;
  logic [ID_BITS-1:0]      cdb_id_2;
  logic [DATA_W-1:0]       cdb_value_2;

  modport slave (
    input  req_valid, req_id, req_value,
    output req_ready,
    output cdb_rdy_1, cdb_id_1, cdb_value_1,
    output cdb_rdy_2, cdb_id_2, cdb_value_2
  );

  modport master (
    output req_valid, req_id, req_value,
    input  req_ready,
    input  cdb_rdy_1, cdb_id_1, cdb_value_1,
    input  cdb_rdy_2, cdb_id_2, cdb_value_2
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to two pending producer results per cycle and
// broadcasts them one cycle later on the two registered CDB channels.
// The scan order is round-robin by default. Defining CDB_FIXED_PRIO_EN turns
// that off: the scan always starts at producer 0, and no rotation pointer is built.
module cdb_arbiter #(
  parameter int NREQ    = 3,
  parameter int ID_BITS = 4,
  parameter int DATA_W  = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [ID_BITS-1:0] id_arr    [NREQ];
  logic [DATA_W-1:0]  value_arr [NREQ];

  logic [PTR_W-1:0]   start_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W-1:0]   g1_idx;
  logic [PTR_W-1:0]   g2_idx;
  logic               g1_found;
  logic               g2_found;
  logic [NREQ-1:0]    grant;
  logic               accept;

  logic               rdy_1_q;
  logic [ID_BITS-1:0] id_1_q;
  logic [DATA_W-1:0]  value_1_q;
  logic               rdy_2_q;
  logic [ID_BITS-1:0] id_2_q;
  logic [DATA_W-1:0]  value_2_q;

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign id_arr[k]    = bus.req_id[k*ID_BITS +: ID_BITS];
    assign value_arr[k] = bus.req_value[k*DATA_W +: DATA_W];
  end

`ifdef CDB_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] last_idx;
  logic [PTR_W-1:0] next_ptr;

  assign start_idx = rr_ptr;
  assign last_idx  = g2_found ? g2_idx : g1_idx;
  assign next_ptr  = (last_idx == PTR_W'(NREQ - 1)) ? '0 : last_idx + 1'b1;
`endif

  // Walk producers from the start index with wrap-around; first two valids win
  always_comb begin
    g1_found = 1'b0;
    g2_found = 1'b0;
    g1_idx   = '0;
    g2_idx   = '0;
    scan_idx = '0;
    grant    = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = PTR_W'((int'(start_idx) + i) % NREQ);
      if (bus.req_valid[scan_idx]) begin
        if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = scan_idx;
        end else if (!g2_found) begin
          g2_found = 1'b1;
          g2_idx   = scan_idx;
        end
      end
    end
    if (g1_found) grant[g1_idx] = 1'b1;
    if (g2_found) grant[g2_idx] = 1'b1;
  end

  assign accept        = rdy_in & ~flush & ~rst_in;
  assign bus.req_ready = grant & {NREQ{accept}};

  // Register the granted results onto the channels; reset/flush squash, pause holds
  always_ff @(posedge clk_in) begin
    if (rst_in || flush) begin
      rdy_1_q   <= 1'b0;
      id_1_q    <= '0;
      value_1_q <= '0;
      rdy_2_q   <= 1'b0;
      id_2_q    <= '0;
      value_2_q <= '0;
`ifndef CDB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else if (rdy_in) begin
      rdy_1_q   <= g1_found;
      id_1_q    <= g1_found ? id_arr[g1_idx]    : '0;
      value_1_q <= g1_found ? value_arr[g1_idx] : '0;
      rdy_2_q   <= g2_found;
      id_2_q    <= g2_found ? id_arr[g2_idx]    : '0;
      value_2_q <= g2_found ? value_arr[g2_idx] : '0;
`ifndef CDB_FIXED_PRIO_EN
      if (g1_found) rr_ptr <= next_ptr;
`endif
    end
  end

  assign bus.cdb_rdy_1   = rdy_1_q;
  assign bus.cdb_id_1    = id_1_q;
  assign bus.cdb_value_1 = value_1_q;
  assign bus.cdb_rdy_2   = rdy_2_q;
  assign bus.cdb_id_2    = id_2_q;
  assign bus.cdb_value_2 = value_2_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the grant rules.
module tb_cdb_arbiter;
  localparam int NREQ    = 3;
  localparam int ID_BITS = 4;
  localparam int DATA_W  = 32;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush;

  cdb_arbiter_if #(.NREQ(NREQ), .ID_BITS(ID_BITS), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.NREQ(NREQ), .ID_BITS(ID_BITS), .DATA_W(DATA_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int passed = 0;
  int total  = 0;

  // Producer-side pending results (held until accepted)
  logic               p_valid [NREQ];
  logic [ID_BITS-1:0] p_id    [NREQ];
  logic [DATA_W-1:0]  p_val   [NREQ];

  // Reference model state
  int                 m_ptr;
  int                 granted[$];
  logic [NREQ-1:0]    e_ready;
  logic               e_rdy1, e_rdy2;
  logic [ID_BITS-1:0] e_id1, e_id2;
  logic [DATA_W-1:0]  e_val1, e_val2;
  logic [NREQ-1:0]    obs_ready;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Producers ahead of the pointer (inclusive) come first, then the rest in index order
  task automatic model_grants();
    int order[$];
    int start;
`ifdef CDB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    granted.delete();
    for (int k = 0; k < NREQ; k++) if (p_valid[k] && k >= start) order.push_back(k);
    for (int k = 0; k < NREQ; k++) if (p_valid[k] && k < start) order.push_back(k);
    if (!rst_in && !flush && rdy_in)
      for (int j = 0; j < order.size() && j < 2; j++) granted.push_back(order[j]);
    e_ready = '0;
    foreach (granted[j]) e_ready[granted[j]] = 1'b1;
  endtask

  // One clock cycle: drive, check the grant, advance the model, check the channels
  task automatic apply_stimulus();
    for (int k = 0; k < NREQ; k++) begin
      bus.req_valid[k]                     = p_valid[k];
      bus.req_id[k*ID_BITS +: ID_BITS]     = p_id[k];
      bus.req_value[k*DATA_W +: DATA_W]    = p_val[k];
    end
    #1;
    model_grants();
    obs_ready = bus.req_ready;
    check_output("req_ready", 64'(obs_ready), 64'(e_ready));
    if (rst_in || flush) begin
      e_rdy1 = 1'b0; e_id1 = '0; e_val1 = '0;
      e_rdy2 = 1'b0; e_id2 = '0; e_val2 = '0;
      m_ptr  = 0;
    end else if (rdy_in) begin
      e_rdy1 = 1'b0; e_id1 = '0; e_val1 = '0;
      e_rdy2 = 1'b0; e_id2 = '0; e_val2 = '0;
      if (granted.size() > 0) begin
        e_rdy1 = 1'b1; e_id1 = p_id[granted[0]]; e_val1 = p_val[granted[0]];
        m_ptr  = (granted[granted.size()-1] + 1) % NREQ;
      end
      if (granted.size() > 1) begin
        e_rdy2 = 1'b1; e_id2 = p_id[granted[1]]; e_val2 = p_val[granted[1]];
      end
      foreach (granted[j]) p_valid[granted[j]] = 1'b0;
    end
    @(posedge clk_in);
    @(negedge clk_in);
    check_output("cdb_rdy_1",   64'(bus.cdb_rdy_1),   64'(e_rdy1));
    check_output("cdb_id_1",    64'(bus.cdb_id_1),    64'(e_id1));
    check_output("cdb_value_1", 64'(bus.cdb_value_1), 64'(e_val1));
    check_output("cdb_rdy_2",   64'(bus.cdb_rdy_2),   64'(e_rdy2));
    check_output("cdb_id_2",    64'(bus.cdb_id_2),    64'(e_id2));
    check_output("cdb_value_2", 64'(bus.cdb_value_2), 64'(e_val2));
  endtask

  task automatic clear_producers();
    for (int k = 0; k < NREQ; k++) p_valid[k] = 1'b0;
  endtask

  // Refill every producer that has no pending result with a fresh one
  task automatic refill_all(input int seed_base);
    for (int k = 0; k < NREQ; k++)
      if (!p_valid[k]) begin
        p_valid[k] = 1'b1;
        p_id[k]    = ID_BITS'(seed_base + k + 1);
        p_val[k]   = 32'hC0DE_0000 + 32'(seed_base * 16 + k);
      end
  endtask

  logic [NREQ-1:0] fair_tab [3];

  initial begin
`ifdef CDB_FIXED_PRIO_EN
    fair_tab = '{3'b011, 3'b011, 3'b011};
`else
    fair_tab = '{3'b011, 3'b101, 3'b110};
`endif
    m_ptr  = 0;
    e_rdy1 = 1'b0; e_id1 = '0; e_val1 = '0;
    e_rdy2 = 1'b0; e_id2 = '0; e_val2 = '0;
    flush  = 1'b0;
    rdy_in = 1'b1;

    // Reset held two cycles with every producer requesting
    rst_in = 1'b1;
    clear_producers();
    refill_all(0);
    apply_stimulus();
    apply_stimulus();
    rst_in = 1'b0;
    clear_producers();

    // Single producer 1 result, then idle
    p_valid[1] = 1'b1; p_id[1] = 4'd5; p_val[1] = 32'hDEAD;
    apply_stimulus();
    check_output("single_ready", 64'(obs_ready), 64'(3'b010));
    check_output("single_id", 64'(bus.cdb_id_1), 64'd5);
    check_output("single_value", 64'(bus.cdb_value_1), 64'hDEAD);
    apply_stimulus();

    // Flush an idle cycle so the pointer restarts at 0, then all three request for 3 cycles
    flush = 1'b1;
    apply_stimulus();
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      refill_all(4 * c + 2);
      apply_stimulus();
      check_output("fair_grant", 64'(obs_ready), 64'(fair_tab[c]));
    end

    // Pause with two requests outstanding, then release
    clear_producers();
    p_valid[0] = 1'b1; p_id[0] = 4'd3; p_val[0] = 32'h1111_0000;
    p_valid[2] = 1'b1; p_id[2] = 4'd7; p_val[2] = 32'h2222_0000;
    rdy_in = 1'b0;
    for (int c = 0; c < 4; c++) apply_stimulus();
    rdy_in = 1'b1;
    apply_stimulus();
    check_output("pause_release", 64'(obs_ready), 64'(3'b101));

    // Grant producer 2, flush while producer 0 waits, then producer 0 goes through
    clear_producers();
    p_valid[2] = 1'b1; p_id[2] = 4'd9; p_val[2] = 32'h9999_9999;
    apply_stimulus();
    check_output("flush_pre_id", 64'(bus.cdb_id_1), 64'd9);
    p_valid[0] = 1'b1; p_id[0] = 4'd4; p_val[0] = 32'h4444_4444;
    flush = 1'b1;
    apply_stimulus();
    flush = 1'b0;
    apply_stimulus();
    check_output("flush_post", 64'(obs_ready), 64'(3'b001));

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      rst_in = ($urandom_range(49) == 0);
      flush  = ($urandom_range(19) == 0);
      rdy_in = ($urandom_range(4) != 0);
      for (int k = 0; k < NREQ; k++)
        if (!p_valid[k] && $urandom_range(1) == 1) begin
          p_valid[k] = 1'b1;
          p_id[k]    = ID_BITS'($urandom);
          p_val[k]   = $urandom;
        end
      apply_stimulus();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
